// File: rtl/uart_tx.sv
// UART serial transmitter: start bit, DBIT data bits (LSB first), optional even
// parity bit (compiled in with UART_TX_PARITY_EN) and one stop bit, paced by s_tick.
module uart_tx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tx_start,
  input  logic            s_tick,
  input  logic [DBIT-1:0] d_in,
  output logic            tx,
  output logic            tx_done,
  output logic            tx_busy
);

  localparam int TW = (SB_TICK > 1) ? $clog2(SB_TICK) : 1;
  localparam int BW = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(SB_TICK - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DBIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DBIT-1:0] shreg_q, shreg_d;
  logic            tx_q, tx_d;
  logic            done_q, done_d;
`ifdef UART_TX_PARITY_EN
  logic            par_q, par_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    tx_d       = tx_q;
    done_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d      = par_q;
`endif
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (tx_start) begin
          shreg_d    = d_in;
          tick_cnt_d = '0;
          tx_d       = 1'b0;
          state_d    = START;
`ifdef UART_TX_PARITY_EN
          par_d      = ^d_in;
`endif
        end
      end
      START: begin
        if (s_tick) begin
          if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            tx_d       = shreg_q[0];
            state_d    = DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_d = '0;
            shreg_d    = shreg_q >> 1;
            if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
              tx_d    = par_q;
              state_d = PARITY;
`else
              tx_d    = 1'b1;
              state_d = STOP;
`endif
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
              // after the shift, bit 0 holds the next data bit to send
              tx_d      = shreg_d[0];
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (s_tick) begin
          if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_d = '0;
            tx_d       = 1'b1;
            state_d    = STOP;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (s_tick) begin
          if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_d = '0;
            done_d     = 1'b1;
            state_d    = IDLE;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  assign tx      = tx_q;
  assign tx_done = done_q;
  assign tx_busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: table of frames with hand-written line patterns
// (bit i of a frame word = line level in bit slot i), plus reset/poke/back-to-back sequences.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       reset, tx_start, s_tick;
  logic [7:0] d_in;
  logic       tx, tx_done, tx_busy;

  int checks   = 0;
  int failures = 0;

`ifdef UART_TX_PARITY_EN
  localparam int NSLOT = 11;
`else
  localparam int NSLOT = 10;
`endif

  uart_tx #(.DBIT(8), .SB_TICK(16)) dut (
    .clk(clk), .reset(reset), .tx_start(tx_start), .s_tick(s_tick),
    .d_in(d_in), .tx(tx), .tx_done(tx_done), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  data;
    int          period;
    logic [9:0]  f_np;
    logic [10:0] f_p;
  } vec_t;

  vec_t vecs[5];

  function automatic logic [10:0] pick(input logic [9:0] f_np, input logic [10:0] f_p);
`ifdef UART_TX_PARITY_EN
    return f_p;
`else
    return {1'b0, f_np};
`endif
  endfunction

  task automatic check(input string name, input int n, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%b want=%b", name, n, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [7:0] data);
    d_in     = data;
    tx_start = 1'b1;
    s_tick   = 1'b0;
    step();
  endtask

  task automatic idle_check(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      tx_start = 1'b0;
      s_tick   = 1'b1;
      step();
      check("idle_tx", i, tx, 1'b1);
      check("idle_busy", i, tx_busy, 1'b0);
      check("idle_done", i, tx_done, 1'b0);
    end
    s_tick = 1'b0;
  endtask

  // Called right after edge E0. s_tick is high on every period-th edge after E0,
  // so slot k spans E(16*period*k) .. E(16*period*(k+1)).
  task automatic run_frame(input logic [10:0] frame, input int period,
                           input logic hold_start, input int poke_at, input int abort_at);
    int len;
    len = NSLOT * 16 * period;
    check("start_tx", 0, tx, frame[0]);
    check("start_busy", 0, tx_busy, 1'b1);
    check("start_done", 0, tx_done, 1'b0);
    if (!hold_start) tx_start = 1'b0;
    for (int n = 0; n < len; n++) begin
      s_tick = ((n + 1) % period == 0);
      if (n == poke_at) begin
        d_in     = 8'hFF;
        tx_start = 1'b1;
      end else if (!hold_start) begin
        tx_start = 1'b0;
      end
      if (n == abort_at) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_tx", n + 1, tx, 1'b1);
        check("abort_busy", n + 1, tx_busy, 1'b0);
        check("abort_done", n + 1, tx_done, 1'b0);
        s_tick = 1'b0;
        return;
      end
      step();
      if (n + 1 < len) begin
        check("tx", n + 1, tx, frame[(n + 1) / (16 * period)]);
        check("busy", n + 1, tx_busy, 1'b1);
        check("done", n + 1, tx_done, 1'b0);
      end else begin
        check("end_tx", n + 1, tx, 1'b1);
        check("end_busy", n + 1, tx_busy, 1'b0);
        check("end_done", n + 1, tx_done, 1'b1);
      end
    end
    s_tick = 1'b0;
  endtask

  initial begin
    //                data   per  no-parity frame   parity frame
    vecs[0] = '{8'hA5, 1, 10'b1101001010, 11'b10101001010};
    vecs[1] = '{8'h3C, 4, 10'b1001111000, 11'b10001111000};
    vecs[2] = '{8'h00, 2, 10'b1000000000, 11'b10000000000};
    vecs[3] = '{8'h07, 1, 10'b1000001110, 11'b11000001110};
    vecs[4] = '{8'h03, 3, 10'b1000000110, 11'b10000000110};

    reset = 1'b1; tx_start = 1'b0; s_tick = 1'b0; d_in = 8'h00;
    repeat (3) step();
    check("rst_tx", 0, tx, 1'b1);
    check("rst_done", 0, tx_done, 1'b0);
    check("rst_busy", 0, tx_busy, 1'b0);
    reset = 1'b0;
    idle_check(5);

    for (int v = 0; v < 5; v++) begin
      $display("vector %0d data=%h period=%0d", v, vecs[v].data, vecs[v].period);
      launch(vecs[v].data);
      run_frame(pick(vecs[v].f_np, vecs[v].f_p), vecs[v].period, 1'b0, -1, -1);
      idle_check(3);
    end

    // d_in change and tx_start during DATA must not disturb the frame
    $display("sequence poke_during_data");
    launch(8'hA5);
    run_frame(pick(10'b1101001010, 11'b10101001010), 1, 1'b0, 40, -1);
    idle_check(40);

    // reset sampled at E70 aborts the frame silently; next frame is clean
    $display("sequence reset_mid_frame");
    launch(8'hA5);
    run_frame(pick(10'b1101001010, 11'b10101001010), 1, 1'b0, -1, 69);
    idle_check(200);
    launch(8'h00);
    run_frame(pick(10'b1000000000, 11'b10000000000), 1, 1'b0, -1, -1);
    idle_check(3);

    // tx_start held across tx_done: second start bit right after the done cycle
    $display("sequence back_to_back");
    launch(8'h01);
    d_in = 8'h80;
    run_frame(pick(10'b1000000010, 11'b11000000010), 1, 1'b1, -1, -1);
    step();
    tx_start = 1'b0;
    run_frame(pick(10'b1100000000, 11'b11100000000), 1, 1'b0, -1, -1);
    idle_check(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
